one_hot_scan_decoder: RTL and testbench

ONE_HOT_SCAN_DECODER -- requirements
Module: one_hot_scan_decoder

---
 rtl/one_hot_scan_decoder.sv | 127 ++++++++++++
 tb/tb_one_hot_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_scan_decoder.sv
// one_hot_scan_decoder
// Registered one-hot decoder with a direct mode (decode sel) and an auto-scan
// mode that walks a single asserted bit across all OUT_W positions, holding
// each position for dwell+1 cycles and pulsing wrap on the roll back to 0.
// The operating state is chosen afresh at every edge from en/mode; the
// previous state only matters for telling a SCAN entry from a SCAN continuation.

module one_hot_scan_decoder #(
   parameter  int unsigned SEL_W   = 4,
   parameter  int unsigned DWELL_W = 8,
   localparam int unsigned OUT_W   = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   out,
   output logic [SEL_W-1:0]   idx,
   output logic               wrap
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   // Registered state and outputs
   state_t             r_state;
   logic [OUT_W-1:0]   r_out;
   logic [SEL_W-1:0]   r_idx;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_wrap;

   // Next-state values
   state_t             w_state_nxt;
   logic [OUT_W-1:0]   w_out_nxt;
   logic [SEL_W-1:0]   w_idx_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic               w_wrap_nxt;

   // Helper terms
   logic [SEL_W-1:0]   w_idx_inc;
   logic               w_cnt_zero;
   logic               w_idx_last;
   logic               w_scan_entry;

   // Single-bit decode of an index; the result is always exactly one-hot.
   function automatic logic [OUT_W-1:0] f_decode(input logic [SEL_W-1:0] i_sel);
      logic [OUT_W-1:0] v;
      v        = '0;
      v[i_sel] = 1'b1;
      return v;
   endfunction

   // The SEL_W-bit increment wraps naturally, giving idx+1 modulo OUT_W.
   assign w_idx_inc    = r_idx + SEL_W'(1);
   assign w_cnt_zero   = (r_cnt == '0);
   assign w_idx_last   = (r_idx == '1);
   assign w_scan_entry = (r_state != ST_SCAN);

   // Next-state selection and per-state datapath updates
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_out_nxt   = r_out;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_wrap_nxt  = 1'b0;

      if (en) begin
         w_state_nxt = mode ? ST_SCAN : ST_DIRECT;
      end

      case (w_state_nxt)
         ST_IDLE: begin
            // idx and dwell counter are held so a later scan resumes in place
            w_out_nxt = '0;
         end
         ST_DIRECT: begin
            w_out_nxt = f_decode(sel);
            w_idx_nxt = sel;
         end
         ST_SCAN: begin
            if (w_scan_entry) begin
               // A state change always wins over a pending advance: entering
               // SCAN re-asserts the held idx and starts a full dwell.
               w_out_nxt = f_decode(r_idx);
               w_cnt_nxt = dwell;
            end else if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - DWELL_W'(1);
            end else begin
               w_idx_nxt  = w_idx_inc;
               w_out_nxt  = f_decode(w_idx_inc);
               w_cnt_nxt  = dwell;
               w_wrap_nxt = w_idx_last;
            end
         end
         default: begin
            w_out_nxt = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign out  = r_out;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_one_hot_scan_decoder.sv
// tb_one_hot_scan_decoder
// Directed stimulus with a cycle-level reference model (position / age /
// hold-length bookkeeping) compared against the DUT on every falling edge,
// plus literal expectations at the points of interest.

module tb_one_hot_scan_decoder;

   localparam int SEL_W   = 4;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 16;

   logic               clk   = 1'b0;
   logic               rst_n = 1'b0;
   logic               en    = 1'b0;
   logic               mode  = 1'b0;
   logic [SEL_W-1:0]   sel   = '0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [OUT_W-1:0]   out;
   logic [SEL_W-1:0]   idx;
   logic               wrap;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   one_hot_scan_decoder #(
      .SEL_W   (SEL_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .sel   (sel),
      .dwell (dwell),
      .out   (out),
      .idx   (idx),
      .wrap  (wrap)
   );

   // Reference model: m_pos is the asserted bit (-1 = none), m_age counts the
   // cycles the current scan position has been shown, m_hold is its dwell.
   bit m_valid = 1'b0;
   bit m_scan  = 1'b0;
   bit m_wrap  = 1'b0;
   int m_pos   = -1;
   int m_idx   = 0;
   int m_age   = 0;
   int m_hold  = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b1;
         m_pos   <= -1;
         m_idx   <= 0;
         m_wrap  <= 1'b0;
         m_scan  <= 1'b0;
         m_age   <= 0;
      end else if (!en) begin
         m_pos  <= -1;
         m_wrap <= 1'b0;
         m_scan <= 1'b0;
      end else if (!mode) begin
         m_pos  <= int'(sel);
         m_idx  <= int'(sel);
         m_wrap <= 1'b0;
         m_scan <= 1'b0;
      end else if (!m_scan) begin
         m_scan <= 1'b1;
         m_pos  <= m_idx;
         m_age  <= 1;
         m_hold <= int'(dwell);
         m_wrap <= 1'b0;
      end else if (m_age <= m_hold) begin
         m_age  <= m_age + 1;
         m_wrap <= 1'b0;
      end else begin
         m_idx  <= (m_idx + 1) % OUT_W;
         m_pos  <= (m_idx + 1) % OUT_W;
         m_age  <= 1;
         m_hold <= int'(dwell);
         m_wrap <= (((m_idx + 1) % OUT_W) == 0);
      end
   end

   function automatic logic [OUT_W-1:0] model_out(input int pos);
      logic [OUT_W-1:0] v;
      v = '0;
      if (pos >= 0) v[pos] = 1'b1;
      return v;
   endfunction

   // Every-cycle comparison against the model once reset has been seen
   always @(negedge clk) begin
      if (m_valid) begin
         n_checks++;
         if (out !== model_out(m_pos) || idx !== 4'(m_idx) || wrap !== m_wrap) begin
            n_fail++;
            $display("FAIL model t=%0t out=%h exp=%h idx=%0d exp=%0d wrap=%0b exp=%0b",
                     $time, out, model_out(m_pos), idx, m_idx, wrap, m_wrap);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
      end
   endtask

   initial begin
      // Reset with en=1, mode=1 held
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; dwell = 8'd2; sel = 4'h0;
      ticks(2);
      chk("rst_out",  32'(out),  32'h0000);
      chk("rst_idx",  32'(idx),  32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);

      // Full scan with dwell=2: three cycles per position
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 48; c++) begin
         logic [OUT_W-1:0] e;
         e = '0;
         e[c / 3] = 1'b1;
         chk("scan_out", 32'(out), 32'(e));
         tick();
      end
      chk("scan_roll_out",  32'(out),  32'h0001);
      chk("scan_roll_wrap", 32'(wrap), 32'h1);
      chk("scan_roll_idx",  32'(idx),  32'h0);
      tick();
      chk("scan_wrap_drop", 32'(wrap), 32'h0);
      chk("scan_hold_out",  32'(out),  32'h0001);

      // dwell=0: one step per cycle, wrap every 16 cycles
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; dwell = 8'd0;
      tick();
      chk("d0_out0", 32'(out), 32'h0001);
      tick();
      chk("d0_out1", 32'(out), 32'h0002);
      tick();
      chk("d0_out2", 32'(out), 32'h0004);
      ticks(14);
      chk("d0_wrap1", 32'(wrap), 32'h1);
      chk("d0_roll",  32'(out),  32'h0001);
      ticks(16);
      chk("d0_wrap2", 32'(wrap), 32'h1);

      // Pause/resume with dwell=3, en dropped while idx=5
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; dwell = 8'd3;
      tick();
      ticks(21);
      chk("pr_pre_out", 32'(out), 32'h0020);
      chk("pr_pre_idx", 32'(idx), 32'h5);
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pr_idle_out", 32'(out), 32'h0000);
         chk("pr_idle_idx", 32'(idx), 32'h5);
      end
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pr_resume_out", 32'(out), 32'h0020);
      end
      tick();
      chk("pr_next_out", 32'(out), 32'h0040);

      // Reset mid-scan at idx=9
      ticks(13);
      chk("mid_idx9", 32'(idx), 32'h9);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_out",  32'(out),  32'h0000);
      chk("mid_rst_idx",  32'(idx),  32'h0);
      chk("mid_rst_wrap", 32'(wrap), 32'h0);

      // Mode switch on a counter-zero edge at idx=15 (would otherwise wrap)
      rst_n = 1'b1; dwell = 8'd0;
      tick();
      ticks(15);
      chk("ms_pre_out", 32'(out), 32'h8000);
      mode = 1'b0; sel = 4'h3;
      tick();
      chk("ms_out",  32'(out),  32'h0008);
      chk("ms_wrap", 32'(wrap), 32'h0);
      chk("ms_idx",  32'(idx),  32'h3);

      // Direct decode then disable
      sel = 4'hA;
      tick();
      chk("dir_out", 32'(out), 32'h0400);
      chk("dir_idx", 32'(idx), 32'hA);
      en = 1'b0;
      tick();
      chk("dir_off_out", 32'(out), 32'h0000);
      chk("dir_off_idx", 32'(idx), 32'hA);

      // Resume scan at held idx, then change dwell mid-position
      en = 1'b1; mode = 1'b1; dwell = 8'd0;
      tick();
      chk("rs_entry", 32'(out), 32'h0400);
      dwell = 8'd3;
      tick();
      chk("dw_adv", 32'(out), 32'h0800);
      dwell = 8'd0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dw_hold", 32'(out), 32'h0800);
      end
      tick();
      chk("dw_next1", 32'(out), 32'h1000);
      tick();
      chk("dw_next2", 32'(out), 32'h2000);

      ticks(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
